// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath mux selects and the bundled control word driven by the main FSM.
package rv_ctrl_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_CMP   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  // One cycle's worth of datapath controls
  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    mem_addr_sel;
    logic    ir_we;
    logic    pc_we;
    pc_sel_e pc_sel;
    logic    alu_a_sel;
    logic    alu_b_sel;
    alu_op_e alu_op;
    logic    rf_we;
    wb_sel_e wb_sel;
  } ctrl_t;

  function automatic logic opc_known(input logic [OPC_W-1:0] opc);
    logic known;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP,
      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI: known = 1'b1;
      default:                                known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits unanswered and flags the
// cycle on which the wait budget is exhausted.
module mem_wait_timer
  #(parameter int unsigned TIMEOUT_CYC = 64)
  (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_wait_c,
    output logic expired_c
  );

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any non-waiting cycle clears, so each new request starts from zero
  always_comb begin
    cnt_d = '0;
    if (mem_wait_c && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign expired_c = mem_wait_c && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and selects, counts retirements and flags fatal errors.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
  #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 32
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ir,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [CNT_W-1:0] instret,
    output logic             err_illegal,
    output logic             err_timeout
  );

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             err_illegal_q;
  logic             err_illegal_d;
  logic             err_timeout_q;
  logic             err_timeout_d;

  ctrl_t            ctrl_c;
  logic             retire_c;
  logic             mem_active_c;
  logic             timeout_c;
  logic [OPC_W-1:0] opc;
  logic             rd_nz;
  logic             unused_ir;

  assign opc       = ir[OPC_W-1:0];
  assign rd_nz     = |ir[11:7];
  assign unused_ir = ^ir[31:12];

  // Request is a pure function of state so reset removes it immediately
  assign mem_active_c = (state_q == S_FETCH) || (state_q == S_MEM);

  mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_wait_c (mem_active_c && !mem_ready),
    .expired_c  (timeout_c)
  );

  always_comb begin
    ctrl_c        = '0;
    state_d       = state_q;
    retire_c      = 1'b0;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        ctrl_c.mem_req      = 1'b1;
        ctrl_c.mem_addr_sel = 1'b0;
        ctrl_c.ir_we        = mem_ready;
        if (mem_ready) begin
          ctrl_c.pc_we  = 1'b1;
          ctrl_c.pc_sel = PC_PLUS4;
          state_d       = S_DECODE;
        end else if (timeout_c) begin
          state_d       = S_HALT;
          err_timeout_d = 1'b1;
        end
      end

      S_DECODE: begin
        if (opc_known(opc)) begin
          state_d = S_EXEC;
        end else begin
          state_d       = S_HALT;
          err_illegal_d = 1'b1;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opc)
          OPC_LOAD, OPC_STORE: begin
            ctrl_c.alu_b_sel = 1'b1;
            ctrl_c.alu_op    = ALU_ADD;
            state_d          = S_MEM;
          end
          OPC_OPIMM: begin
            ctrl_c.alu_b_sel = 1'b1;
            ctrl_c.alu_op    = ALU_FUNCT;
            state_d          = S_WB;
          end
          OPC_OP: begin
            ctrl_c.alu_b_sel = 1'b0;
            ctrl_c.alu_op    = ALU_FUNCT;
            state_d          = S_WB;
          end
          OPC_BRANCH: begin
            ctrl_c.alu_op = ALU_CMP;
            ctrl_c.pc_we  = br_taken;
            ctrl_c.pc_sel = br_taken ? PC_IMM : PC_PLUS4;
            retire_c      = 1'b1;
          end
          OPC_JAL: begin
            ctrl_c.rf_we  = 1'b1;
            ctrl_c.wb_sel = WB_PC4;
            ctrl_c.pc_we  = 1'b1;
            ctrl_c.pc_sel = PC_IMM;
            retire_c      = 1'b1;
          end
          OPC_JALR: begin
            ctrl_c.alu_b_sel = 1'b1;
            ctrl_c.rf_we     = 1'b1;
            ctrl_c.wb_sel    = WB_PC4;
            ctrl_c.pc_we     = 1'b1;
            ctrl_c.pc_sel    = PC_ALU;
            retire_c         = 1'b1;
          end
          OPC_LUI: begin
            ctrl_c.rf_we  = 1'b1;
            ctrl_c.wb_sel = WB_IMM;
            retire_c      = 1'b1;
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        ctrl_c.mem_req      = 1'b1;
        ctrl_c.mem_addr_sel = 1'b1;
        ctrl_c.mem_we       = (opc == OPC_STORE);
        if (mem_ready) begin
          if (opc == OPC_STORE) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end else if (timeout_c) begin
          state_d       = S_HALT;
          err_timeout_d = 1'b1;
        end
      end

      S_WB: begin
        ctrl_c.rf_we  = 1'b1;
        ctrl_c.wb_sel = (opc == OPC_LOAD) ? WB_MEM : WB_ALU;
        retire_c      = 1'b1;
        state_d       = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Writes to x0 are dropped; the instruction still retires
    if (!rd_nz) begin
      ctrl_c.rf_we = 1'b0;
    end

    instret_d = instret_q + CNT_W'(retire_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instret_q     <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instret_q     <= instret_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign mem_req      = ctrl_c.mem_req;
  assign mem_we       = ctrl_c.mem_we;
  assign mem_addr_sel = ctrl_c.mem_addr_sel;
  assign ir_we        = ctrl_c.ir_we;
  assign pc_we        = ctrl_c.pc_we;
  assign pc_sel       = ctrl_c.pc_sel;
  assign alu_a_sel    = ctrl_c.alu_a_sel;
  assign alu_b_sel    = ctrl_c.alu_b_sel;
  assign alu_op       = ctrl_c.alu_op;
  assign rf_we        = ctrl_c.rf_we;
  assign wb_sel       = ctrl_c.wb_sel;
  assign instret      = instret_q;
  assign err_illegal  = err_illegal_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected phase
// sequence and per-cycle control word, then compared against the DUT cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       asel;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcs;
    logic       a;
    logic       b;
    logic [1:0] op;
    logic       rf;
    logic [1:0] wb;
  } cv_t;

  logic [6:0] legal_ops [8] = '{OP_LOAD, OP_STORE, OP_OPIMM, OP_R,
                                OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
  logic [6:0] bad_ops [5]   = '{7'h00, 7'h7F, 7'b0001111, 7'b1110011, 7'b0010111};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   ir = 32'h0;
  logic          br_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]    pc_sel;
  logic          alu_a_sel, alu_b_sel;
  logic [1:0]    alu_op;
  logic          rf_we;
  logic [1:0]    wb_sel;
  logic [CW-1:0] instret;
  logic          err_illegal, err_timeout;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_instret = 0;
  logic exp_ill = 1'b0;
  logic exp_to = 1'b0;
  logic halted = 1'b0;

  multicycle_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir           (ir),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .instret      (instret),
    .err_illegal  (err_illegal),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic cv_t obs_vec();
    cv_t o;
    o = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
         alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel};
    return o;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    logic hit = 1'b0;
    for (int i = 0; i < 8; i++) if (legal_ops[i] == op) hit = 1'b1;
    return hit;
  endfunction

  // Control word expected in the execute phase, straight from the opcode table
  function automatic cv_t exec_exp(input logic [6:0] op, input logic rdnz, input logic br);
    cv_t e = '0;
    if (op == OP_LOAD || op == OP_STORE) begin
      e.b = 1'b1;
    end else if (op == OP_OPIMM) begin
      e.b = 1'b1; e.op = 2'd2;
    end else if (op == OP_R) begin
      e.op = 2'd2;
    end else if (op == OP_BRANCH) begin
      e.op = 2'd1; e.pcwe = br; e.pcs = br ? 2'd1 : 2'd0;
    end else if (op == OP_JAL) begin
      e.rf = rdnz; e.wb = 2'd2; e.pcwe = 1'b1; e.pcs = 2'd1;
    end else if (op == OP_JALR) begin
      e.b = 1'b1; e.rf = rdnz; e.wb = 2'd2; e.pcwe = 1'b1; e.pcs = 2'd2;
    end else if (op == OP_LUI) begin
      e.rf = rdnz; e.wb = 2'd3;
    end
    return e;
  endfunction

  task automatic step(input string tag, input cv_t e);
    @(negedge clk);
    check_eq(tag, 32'(obs_vec()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic status_checks(input string tag);
    check_eq({tag, "_instret"}, 32'(instret), 32'(exp_instret % (1 << CW)));
    check_eq({tag, "_err_ill"}, 32'(err_illegal), 32'(exp_ill));
    check_eq({tag, "_err_to"}, 32'(err_timeout), 32'(exp_to));
  endtask

  task automatic halt_phase();
    status_checks("halt_entry");
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom);
      br_taken  = 1'($urandom);
      step("halt", '0);
    end
    status_checks("halt_stay");
    halted = 1'b1;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic do_reset(input logic expect_req);
    if (expect_req) check_eq("rst_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_instret = 0; exp_ill = 1'b0; exp_to = 1'b0; halted = 1'b0;
    check_eq("rst_outputs", 32'(obs_vec()), 32'd0);
    status_checks("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'($urandom);
    step("idle", '0);
  endtask

  // Fetch latency / mem latency >= TO means the memory never answers
  task automatic run_instr(input logic [31:0] ir_v, input int fl, input int ml, input logic br);
    logic [6:0] op;
    logic       rdnz;
    cv_t        e;
    op   = ir_v[6:0];
    rdnz = |ir_v[11:7];

    for (int c = 0; c < int'(TO); c++) begin
      mem_ready = (c == fl);
      br_taken  = 1'($urandom);
      e = '0; e.req = 1'b1; e.irwe = mem_ready; e.pcwe = mem_ready;
      step("fetch", e);
      if (c == fl) begin
        ir = ir_v;
        break;
      end
    end
    if (fl >= int'(TO)) begin
      exp_to = 1'b1;
      halt_phase();
      return;
    end

    mem_ready = 1'($urandom);
    br_taken  = 1'($urandom);
    step("decode", '0);
    if (!is_legal(op)) begin
      exp_ill = 1'b1;
      halt_phase();
      return;
    end

    mem_ready = 1'($urandom);
    br_taken  = br;
    step("exec", exec_exp(op, rdnz, br));
    if (op == OP_BRANCH || op == OP_JAL || op == OP_JALR || op == OP_LUI) begin
      exp_instret++;
      status_checks("exec_retire");
      return;
    end

    if (op == OP_LOAD || op == OP_STORE) begin
      for (int c = 0; c < int'(TO); c++) begin
        mem_ready = (c == ml);
        br_taken  = 1'($urandom);
        e = '0; e.req = 1'b1; e.asel = 1'b1; e.we = (op == OP_STORE);
        step("mem", e);
        if (c == ml) break;
      end
      if (ml >= int'(TO)) begin
        exp_to = 1'b1;
        halt_phase();
        return;
      end
      if (op == OP_STORE) begin
        exp_instret++;
        status_checks("store_retire");
        return;
      end
    end

    mem_ready = 1'($urandom);
    br_taken  = 1'($urandom);
    e = '0; e.rf = rdnz; e.wb = (op == OP_LOAD) ? 2'd1 : 2'd0;
    step("wb", e);
    exp_instret++;
    status_checks("wb_retire");
  endtask

  function automatic int rand_lat();
    int r = int'($urandom_range(0, 19));
    if (r == 0) return int'(TO);
    if (r < 10) return 0;
    return int'($urandom_range(1, TO - 1));
  endfunction

  initial begin
    logic [31:0] r;
    logic [4:0]  rd;
    logic [6:0]  op;
    int          k;

    #2;
    do_reset(1'b0);

    run_instr(32'h00500093, 0, 0, 1'b0);      // ADDI x1,x0,5
    run_instr(32'h00002083, 0, 3, 1'b0);      // LW x1,0(x0), slow memory
    run_instr(32'h00000463, 1, 0, 1'b1);      // BEQ taken
    run_instr(32'h00000463, 0, 0, 1'b0);      // BEQ not taken
    run_instr(32'h00112023, 2, 1, 1'b0);      // SW
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0);      // illegal
    do_reset(1'b0);
    run_instr(32'h00500093, int'(TO), 0, 1'b0);      // fetch timeout
    do_reset(1'b0);
    run_instr(32'h00500093, int'(TO) - 1, 0, 1'b0);  // answer on last allowed cycle
    run_instr(32'h00002083, 0, int'(TO) - 1, 1'b0);
    do_reset(1'b1);                                  // reset while fetching
    for (int i = 0; i < 18; i++) begin               // counter wrap
      r = $urandom;
      run_instr({r[31:12], 5'(i), OP_OPIMM}, int'($urandom_range(0, TO - 1)), 0, 1'b0);
    end

    for (int n = 0; n < 400; n++) begin
      if (halted) do_reset(1'b0);
      else if ($urandom_range(0, 49) == 0) do_reset(1'b1);
      k = int'($urandom_range(0, 39));
      if (k < 38) op = legal_ops[k % 8];
      else op = bad_ops[$urandom_range(0, 4)];
      r  = $urandom;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_instr({r[31:12], rd, op}, rand_lat(), rand_lat(), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
